// File: rtl/bus_stim_mem.sv
// Bus stimulus memory: loader-filled RAM + vector bank, bus-cycle counter and timed IRQ/NMI slots.
// Optional CPU write log (wr_last_addr/wr_last_data/wr_count) enabled by defining STIM_WRLOG_EN.
module bus_stim_mem #(
   parameter int unsigned MEM_AW = 12,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned N_EVT  = 4
) (
   input  logic             clk_ph1,
   input  logic             rst,
   input  logic             run,
   input  logic [15:0]      Addr_bus,
   input  logic             R_nW,
   input  logic [7:0]       Data_bus_out,
   output logic [7:0]       Data_bus_in,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [15:0]      ld_addr,
   input  logic [7:0]       ld_data,
   input  logic             evt_wr,
   input  logic [3:0]       evt_idx,
   input  logic [CNT_W-1:0] evt_start,
   input  logic [CNT_W-1:0] evt_len,
   input  logic             evt_nmi,
   input  logic             evt_en,
   output logic             irq,
   output logic             nmi,
   output logic [CNT_W-1:0] cycle_count,
   output logic             oor_flag,
   output logic [15:0]      wr_last_addr,
   output logic [7:0]       wr_last_data,
   output logic [CNT_W-1:0] wr_count
);
   localparam int unsigned RAM_DEPTH = 1 << MEM_AW;
   localparam int unsigned VEC_N     = 6;
   localparam logic [15:0] VEC_BASE  = 16'hFFFA;

   typedef struct packed {
      logic [CNT_W-1:0] start;
      logic [CNT_W-1:0] len;
      logic             nmi;
      logic             en;
   } evt_slot_t;

   logic [7:0]        ram [RAM_DEPTH];
   logic [7:0]        vec [VEC_N];
   evt_slot_t         slot_q [N_EVT];

   logic              cpu_in_ram, cpu_in_vec, ld_in_ram, ld_in_vec;
   logic [2:0]        cpu_vec_idx, ld_vec_idx;
   logic              cpu_wr, ld_wr;
   logic              ram_we, vec_we;
   logic [MEM_AW-1:0] ram_widx;
   logic [2:0]        vec_widx;
   logic [7:0]        wr_byte;
   logic              irq_act, nmi_act;

   // Address decode; RAM takes priority should it ever cover the vector bank
   assign cpu_in_ram  = 32'(Addr_bus) < RAM_DEPTH;
   assign cpu_in_vec  = !cpu_in_ram && (Addr_bus >= VEC_BASE);
   assign ld_in_ram   = 32'(ld_addr) < RAM_DEPTH;
   assign ld_in_vec   = !ld_in_ram && (ld_addr >= VEC_BASE);
   assign cpu_vec_idx = 3'(Addr_bus - VEC_BASE);
   assign ld_vec_idx  = 3'(ld_addr - VEC_BASE);

   assign ld_ready = !run;
   assign cpu_wr   = run && !R_nW && cpu_in_ram;
   assign ld_wr    = !run && ld_valid;

   always_comb begin
      Data_bus_in = 8'h00;
      if (cpu_in_ram)
         Data_bus_in = ram[Addr_bus[MEM_AW-1:0]];
      else if (cpu_in_vec)
         Data_bus_in = vec[cpu_vec_idx];
   end

   // Single write port shared by CPU (run=1) and loader (run=0)
   always_comb begin
      ram_we   = 1'b0;
      vec_we   = 1'b0;
      ram_widx = '0;
      vec_widx = '0;
      wr_byte  = 8'h00;
      if (cpu_wr) begin
         ram_we   = 1'b1;
         ram_widx = Addr_bus[MEM_AW-1:0];
         wr_byte  = Data_bus_out;
      end else if (ld_wr) begin
         wr_byte  = ld_data;
         ram_widx = ld_addr[MEM_AW-1:0];
         vec_widx = ld_vec_idx;
         ram_we   = ld_in_ram;
         vec_we   = ld_in_vec;
      end
   end

   // Storage is never reset; a write coinciding with reset is dropped
   always_ff @(posedge clk_ph1) begin
      if (ram_we && !rst)
         ram[ram_widx] <= wr_byte;
   end

   always_ff @(posedge clk_ph1) begin
      if (vec_we && !rst)
         vec[vec_widx] <= wr_byte;
   end

   always_ff @(posedge clk_ph1 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_EVT; i++)
            slot_q[i] <= '0;
      end else if (evt_wr) begin
         for (int i = 0; i < N_EVT; i++)
            if (evt_idx == 4'(i))
               slot_q[i] <= '{start: evt_start, len: evt_len, nmi: evt_nmi, en: evt_en};
      end
   end

   // Window end is computed one bit wider so start+len never wraps
   always_comb begin
      irq_act = 1'b0;
      nmi_act = 1'b0;
      for (int i = 0; i < N_EVT; i++) begin
         if (slot_q[i].en && (cycle_count >= slot_q[i].start) &&
             ({1'b0, cycle_count} < ({1'b0, slot_q[i].start} + {1'b0, slot_q[i].len}))) begin
            if (slot_q[i].nmi)
               nmi_act = 1'b1;
            else
               irq_act = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_ph1 or posedge rst) begin
      if (rst) begin
         cycle_count <= '0;
         irq         <= 1'b1;
         nmi         <= 1'b1;
         oor_flag    <= 1'b0;
      end else begin
         if (run && (cycle_count != '1))
            cycle_count <= cycle_count + CNT_W'(1);
         irq <= !irq_act;
         nmi <= !nmi_act;
         if (run && !cpu_in_ram && !cpu_in_vec)
            oor_flag <= 1'b1;
      end
   end

`ifdef STIM_WRLOG_EN
   always_ff @(posedge clk_ph1 or posedge rst) begin
      if (rst) begin
         wr_last_addr <= '0;
         wr_last_data <= '0;
         wr_count     <= '0;
      end else if (cpu_wr) begin
         wr_last_addr <= Addr_bus;
         wr_last_data <= Data_bus_out;
         if (wr_count != '1)
            wr_count <= wr_count + CNT_W'(1);
      end
   end
`else
   assign wr_last_addr = '0;
   assign wr_last_data = '0;
   assign wr_count     = '0;
`endif

endmodule

// File: tb/tb_bus_stim_mem.sv
// Randomised + directed bench for bus_stim_mem; a behavioural model feeds an expectation queue
// that an independent monitor drains and compares against the DUT every cycle.
module tb_bus_stim_mem;
   localparam int MEM_AW = 12;
   localparam int CNT_W  = 10;
   localparam int N_EVT  = 4;
   localparam int RAM_N  = 1 << MEM_AW;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic             clk_ph1 = 1'b0;
   logic             rst = 1'b1;
   logic             run = 1'b0;
   logic [15:0]      Addr_bus = '0;
   logic             R_nW = 1'b1;
   logic [7:0]       Data_bus_out = '0;
   logic [7:0]       Data_bus_in;
   logic             ld_valid = 1'b0;
   logic             ld_ready;
   logic [15:0]      ld_addr = '0;
   logic [7:0]       ld_data = '0;
   logic             evt_wr = 1'b0;
   logic [3:0]       evt_idx = '0;
   logic [CNT_W-1:0] evt_start = '0;
   logic [CNT_W-1:0] evt_len = '0;
   logic             evt_nmi = 1'b0;
   logic             evt_en = 1'b0;
   logic             irq, nmi, oor_flag;
   logic [CNT_W-1:0] cycle_count;
   logic [15:0]      wr_last_addr;
   logic [7:0]       wr_last_data;
   logic [CNT_W-1:0] wr_count;

   bus_stim_mem #(.MEM_AW(MEM_AW), .CNT_W(CNT_W), .N_EVT(N_EVT)) dut (
      .clk_ph1(clk_ph1), .rst(rst), .run(run), .Addr_bus(Addr_bus), .R_nW(R_nW),
      .Data_bus_out(Data_bus_out), .Data_bus_in(Data_bus_in), .ld_valid(ld_valid),
      .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .evt_wr(evt_wr),
      .evt_idx(evt_idx), .evt_start(evt_start), .evt_len(evt_len), .evt_nmi(evt_nmi),
      .evt_en(evt_en), .irq(irq), .nmi(nmi), .cycle_count(cycle_count), .oor_flag(oor_flag),
      .wr_last_addr(wr_last_addr), .wr_last_data(wr_last_data), .wr_count(wr_count)
   );

   always #5 clk_ph1 = ~clk_ph1;

   typedef struct {
      logic [7:0]  dbi;
      bit          dbi_chk;
      logic        ld_rdy;
      logic        irq;
      logic        nmi;
      int          cnt;
      logic        oor;
      int          wla;
      int          wld;
      int          wc;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state
   byte unsigned m_ram[RAM_N];
   bit           m_known[RAM_N];
   byte unsigned m_vec[6];
   bit           m_vknown[6];
   int  m_cnt, m_wla, m_wld, m_wc;
   bit  m_irq, m_nmi, m_oor;
   int  s_start[N_EVT], s_len[N_EVT];
   bit  s_nmi[N_EVT], s_en[N_EVT];

   int vectors = 0;
   int miscompares = 0;

   function automatic void model_reset();
      m_cnt = 0; m_irq = 1; m_nmi = 1; m_oor = 0;
      m_wla = 0; m_wld = 0; m_wc = 0;
      for (int i = 0; i < N_EVT; i++) s_en[i] = 0;
   endfunction

   function automatic bit slot_active(bit want_nmi);
      bit r = 0;
      for (int i = 0; i < N_EVT; i++)
         if (s_en[i] && s_nmi[i] == want_nmi && m_cnt >= s_start[i] && m_cnt < s_start[i] + s_len[i])
            r = 1;
      return r;
   endfunction

   // One bus cycle: caller has set inputs at a falling edge
   task automatic step();
      exp_t e;
      int a, la;
      bit ni, nn;
      if (rst) model_reset();
      #2;
      a = int'(Addr_bus);
      la = int'(ld_addr);
      e.dbi_chk = 1; e.dbi = 8'h00;
      if (a < RAM_N) begin
         e.dbi_chk = m_known[a]; e.dbi = m_ram[a];
      end else if (a >= 'hFFFA) begin
         e.dbi_chk = m_vknown[a - 'hFFFA]; e.dbi = m_vec[a - 'hFFFA];
      end
      e.ld_rdy = !run; e.irq = m_irq; e.nmi = m_nmi; e.cnt = m_cnt; e.oor = m_oor;
      e.wla = m_wla; e.wld = m_wld; e.wc = m_wc;
      exp_q.push_back(e);
      if (!rst) begin
         ni = !slot_active(0);
         nn = !slot_active(1);
         if (run && a >= RAM_N && a < 'hFFFA) m_oor = 1;
         if (run && !R_nW && a < RAM_N) begin
            m_ram[a] = Data_bus_out; m_known[a] = 1;
`ifdef STIM_WRLOG_EN
            m_wla = a; m_wld = int'(Data_bus_out);
            if (m_wc < CMAX) m_wc++;
`endif
         end
         if (!run && ld_valid) begin
            if (la < RAM_N) begin
               m_ram[la] = ld_data; m_known[la] = 1;
            end else if (la >= 'hFFFA) begin
               m_vec[la - 'hFFFA] = ld_data; m_vknown[la - 'hFFFA] = 1;
            end
         end
         if (evt_wr && int'(evt_idx) < N_EVT) begin
            s_start[evt_idx] = int'(evt_start); s_len[evt_idx] = int'(evt_len);
            s_nmi[evt_idx] = evt_nmi; s_en[evt_idx] = evt_en;
         end
         if (run && m_cnt < CMAX) m_cnt++;
         m_irq = ni; m_nmi = nn;
      end
      @(negedge clk_ph1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load(input logic [15:0] addr, input logic [7:0] data);
      ld_valid = 1; ld_addr = addr; ld_data = data;
      step();
      ld_valid = 0;
   endtask

   task automatic prog(input int idx, input int start, input int len, input bit kind, input bit en);
      evt_wr = 1; evt_idx = 4'(idx); evt_start = CNT_W'(start); evt_len = CNT_W'(len);
      evt_nmi = kind; evt_en = en;
      step();
      evt_wr = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      idle(2);
      rst = 0;
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(3))
         0:       return 16'($urandom_range(31));
         1:       return 16'($urandom_range(16'hFFFF, 16'hFFFA));
         2:       return 16'($urandom);
         default: return 16'($urandom_range(RAM_N + 3, RAM_N - 4));
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compares one queued expectation per cycle, just before the rising edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_ph1);
         #4;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (e.dbi_chk) chk("Data_bus_in", 32'(Data_bus_in), 32'(e.dbi));
            chk("ld_ready", 32'(ld_ready), 32'(e.ld_rdy));
            chk("irq", 32'(irq), 32'(e.irq));
            chk("nmi", 32'(nmi), 32'(e.nmi));
            chk("cycle_count", 32'(cycle_count), 32'(e.cnt));
            chk("oor_flag", 32'(oor_flag), 32'(e.oor));
            chk("wr_last_addr", 32'(wr_last_addr), 32'(e.wla));
            chk("wr_last_data", 32'(wr_last_data), 32'(e.wld));
            chk("wr_count", 32'(wr_count), 32'(e.wc));
         end
      end
   end

   initial begin
      int drain;
      model_reset();
      @(negedge clk_ph1);
      do_reset();

      // Loader fill and readback, including an unmapped read
      load(16'h0000, 8'hA9); load(16'h0001, 8'hAA); load(16'h0002, 8'hC9);
      load(16'h0003, 8'h11); load(16'hFFFA, 8'h00); load(16'hFFFB, 8'h20);
      load(16'h0011, 8'h3C); load(16'h0004, 8'h5A);
      foreach (m_vec[i]) begin Addr_bus = 16'(16'hFFFA + i); step(); end
      for (int i = 0; i < 5; i++) begin Addr_bus = 16'(i); step(); end
      Addr_bus = 16'h1000; step();

      // Loader locked out while running
      Addr_bus = 16'h0004; ld_valid = 1; ld_addr = 16'h0004; ld_data = 8'hFF;
      run = 1; idle(3);
      ld_valid = 0; run = 0; step();

      // IRQ window 5..19
      do_reset();
      prog(0, 5, 15, 0, 1);
      run = 1; Addr_bus = 16'h0000; idle(25);

      // CPU writes, vector write ignored, unmapped access
      R_nW = 0; Addr_bus = 16'h0010; Data_bus_out = 8'hB0; step();
      R_nW = 1; step();
      R_nW = 0; Addr_bus = 16'hFFFA; Data_bus_out = 8'h77; step();
      R_nW = 1; step();
      Addr_bus = 16'h8000; step();
      Addr_bus = 16'h0010; idle(2);

      // Reset mid-pulse with a write in flight
      do_reset();
      prog(1, 2, 100, 0, 1);
      idle(10);
      R_nW = 0; Addr_bus = 16'h0011; Data_bus_out = 8'h55;
      rst = 1; step();
      R_nW = 1; step();
      rst = 0; idle(5);
      run = 0; step();
      Addr_bus = 16'h0010; step();

      // NMI window spanning counter saturation
      do_reset();
      prog(2, CMAX - 1, 4, 1, 1);
      run = 1; idle(CMAX + 10);

      // Randomised traffic
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(99) < 5) run = ~run;
         rst = ($urandom_range(299) == 0);
         Addr_bus = pick_addr();
         R_nW = 1'($urandom_range(1));
         Data_bus_out = 8'($urandom);
         ld_valid = 1'($urandom_range(1));
         ld_addr = pick_addr();
         ld_data = 8'($urandom);
         evt_wr = ($urandom_range(9) == 0);
         evt_idx = 4'($urandom_range(5));
         evt_start = CNT_W'(m_cnt + $urandom_range(20));
         evt_len = CNT_W'($urandom_range(30));
         evt_nmi = 1'($urandom_range(1));
         evt_en = ($urandom_range(3) != 0);
         step();
      end
      rst = 0; evt_wr = 0; ld_valid = 0; R_nW = 1;

      drain = 0;
      while (exp_q.size() != 0 && drain < 5) begin
         @(negedge clk_ph1);
         drain++;
      end
      #5;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
